// File: rtl/ex_ctrl_pkg.sv
// Shared types for the EX-stage hazard controller: forwarding selects,
// controller states and the per-slot control record.
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MULTI_BUSY = 2'b10
    } state_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
    } slot_ctl_t;

    localparam int BUSY_CNT_W = 4;

    // Control bits are forced low for a bubble so no stale write/load leaks downstream.
    function automatic slot_ctl_t slot_from_id(input logic v, input logic rw, input logic mr);
        slot_ctl_t s;
        s.valid     = v;
        s.reg_write = v & rw;
        s.mem_read  = v & mr;
        return s;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Forwarding source for one operand: compares a source register against the
// producers that will sit in MEM and WB during the consumer's EX cycle.
module fwd_match
    import ex_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_mem_valid,
    input  logic                  i_mem_wr,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_wb_valid,
    input  logic                  i_wb_wr,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    output fwd_sel_e              o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_valid && i_mem_wr && (i_mem_rd != '0) && (i_mem_rd == i_rs);
    assign w_wb_hit  = i_wb_valid && i_wb_wr && (i_wb_rd != '0) && (i_wb_rd == i_rs);

    // The younger producer (MEM) holds the most recent value of the register.
    assign o_sel = w_mem_hit ? FWD_MEM : (w_wb_hit ? FWD_WB : FWD_REG);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencing controller: registered forwarding selects, load-use stall,
// taken-branch flush and multi-cycle busy. Define EX_HAZARD_PERF_EN for stall/flush counters.
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MULTI_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_multi,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  flush,
    output logic                  ex_busy,
    output logic [15:0]           stall_count,
    output logic [15:0]           flush_count,
    output state_e                dbg_state,
    output slot_ctl_t             dbg_ex,
    output slot_ctl_t             dbg_mem,
    output slot_ctl_t             dbg_wb,
    output logic [REG_ADDR_W-1:0] dbg_wb_rd
);

    state_e                r_state;
    logic [BUSY_CNT_W-1:0] r_busy_cnt;
    slot_ctl_t             r_ex_ctl, r_mem_ctl, r_wb_ctl;
    logic [REG_ADDR_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    fwd_sel_e              r_fwd_a, r_fwd_b;
    fwd_sel_e              w_sel_a, w_sel_b;

    logic w_run, w_busy, w_flush, w_load_use, w_advance, w_enter_multi;

    assign w_run   = (r_state == ST_RUN);
    assign w_busy  = (r_state == ST_MULTI_BUSY);
    assign w_flush = w_run && r_ex_ctl.valid && ex_branch_taken;

    // A flush squashes the ID instruction, so it cannot also be stalled on.
    assign w_load_use = w_run && !w_flush && id_valid && r_ex_ctl.valid && r_ex_ctl.mem_read
                        && (r_ex_rd != '0) && ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));

    assign w_advance     = !w_busy && !w_load_use && !w_flush;
    assign w_enter_multi = id_valid && id_multi && (MULTI_LAT > 1);

    // Current EX/MEM slots become MEM/WB by the time the ID instruction executes.
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .i_rs       (id_rs1),
        .i_mem_valid(r_ex_ctl.valid),
        .i_mem_wr   (r_ex_ctl.reg_write),
        .i_mem_rd   (r_ex_rd),
        .i_wb_valid (r_mem_ctl.valid),
        .i_wb_wr    (r_mem_ctl.reg_write),
        .i_wb_rd    (r_mem_rd),
        .o_sel      (w_sel_a)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .i_rs       (id_rs2),
        .i_mem_valid(r_ex_ctl.valid),
        .i_mem_wr   (r_ex_ctl.reg_write),
        .i_mem_rd   (r_ex_rd),
        .i_wb_valid (r_mem_ctl.valid),
        .i_wb_wr    (r_mem_ctl.reg_write),
        .i_wb_rd    (r_mem_rd),
        .o_sel      (w_sel_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_busy_cnt <= '0;
            r_ex_ctl   <= '0;
            r_mem_ctl  <= '0;
            r_wb_ctl   <= '0;
            r_ex_rd    <= '0;
            r_mem_rd   <= '0;
            r_wb_rd    <= '0;
            r_fwd_a    <= FWD_REG;
            r_fwd_b    <= FWD_REG;
        end else if (w_busy) begin
            // EX holds the multi-cycle op; MEM takes bubbles while WB drains.
            r_mem_ctl  <= '0;
            r_wb_ctl   <= r_mem_ctl;
            r_wb_rd    <= r_mem_rd;
            r_busy_cnt <= r_busy_cnt - BUSY_CNT_W'(1);
            if (r_busy_cnt == BUSY_CNT_W'(1)) begin
                r_state <= ST_RUN;
            end
        end else begin
            r_wb_ctl  <= r_mem_ctl;
            r_wb_rd   <= r_mem_rd;
            r_mem_ctl <= r_ex_ctl;
            r_mem_rd  <= r_ex_rd;
            if (w_advance) begin
                r_ex_ctl <= slot_from_id(id_valid, id_reg_write, id_mem_read);
                r_ex_rd  <= id_rd;
                r_fwd_a  <= w_sel_a;
                r_fwd_b  <= w_sel_b;
                if (w_enter_multi) begin
                    r_state    <= ST_MULTI_BUSY;
                    r_busy_cnt <= BUSY_CNT_W'(MULTI_LAT - 1);
                end else begin
                    r_state <= ST_RUN;
                end
            end else begin
                r_ex_ctl <= '0;
                r_state  <= w_load_use ? ST_LOAD_STALL : ST_RUN;
            end
        end
    end

    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign stall_if_id = w_busy || w_load_use;
    assign bubble_ex   = w_load_use;
    assign flush       = w_flush;
    assign ex_busy     = w_busy;
    assign dbg_state   = r_state;
    assign dbg_ex      = r_ex_ctl;
    assign dbg_mem     = r_mem_ctl;
    assign dbg_wb      = r_wb_ctl;
    assign dbg_wb_rd   = r_wb_rd;

`ifdef EX_HAZARD_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_if_id && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = 16'd0;
    assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed hazard scenarios followed by random
// instruction streams, all checked against an instruction-level pipeline model.
module tb_ex_hazard_ctrl;
    import ex_ctrl_pkg::*;

    localparam int AW  = 5;
    localparam int LAT = 4;
`ifdef EX_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_reg_write, id_mem_read, id_multi, ex_branch_taken;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall_if_id, bubble_ex, flush, ex_busy;
    logic [15:0]   stall_count, flush_count;
    state_e        dbg_state;
    slot_ctl_t     dbg_ex, dbg_mem, dbg_wb;
    logic [AW-1:0] dbg_wb_rd;

    int n_checks = 0;
    int n_errors = 0;

    ex_hazard_ctrl #(.REG_ADDR_W(AW), .MULTI_LAT(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_multi       (id_multi),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .stall_if_id    (stall_if_id),
        .bubble_ex      (bubble_ex),
        .flush          (flush),
        .ex_busy        (ex_busy),
        .stall_count    (stall_count),
        .flush_count    (flush_count),
        .dbg_state      (dbg_state),
        .dbg_ex         (dbg_ex),
        .dbg_mem        (dbg_mem),
        .dbg_wb         (dbg_wb),
        .dbg_wb_rd      (dbg_wb_rd)
    );

    always #5 clk = ~clk;

    // Instruction-level model: what occupies EX/MEM/WB, busy cycles left, stall history.
    typedef struct {
        bit          v;
        logic [AW-1:0] rd;
        bit          rw;
        bit          mr;
    } minstr_t;

    minstr_t     m_ex, m_mem, m_wb;
    int          m_busy_left;
    bit          m_ls, m_fresh;
    logic [1:0]  m_fwd_a, m_fwd_b;
    logic [15:0] m_sc, m_fc;
    bit          e_busy, e_flush, e_lu, e_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] src(input logic [AW-1:0] rs);
        if (m_ex.v && m_ex.rw && m_ex.rd != 0 && m_ex.rd == rs) return 2'b10;
        if (m_mem.v && m_mem.rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic state_e exp_state();
        if (m_busy_left > 0) return ST_MULTI_BUSY;
        if (m_ls) return ST_LOAD_STALL;
        return ST_RUN;
    endfunction

    task automatic model_update();
        minstr_t nid;
        if (rst) begin
            m_ex = '{default:0}; m_mem = '{default:0}; m_wb = '{default:0};
            m_busy_left = 0; m_ls = 0; m_fresh = 1;
            m_fwd_a = 2'b00; m_fwd_b = 2'b00; m_sc = 16'd0; m_fc = 16'd0;
        end else begin
            m_fresh = 0;
            if (PERF && e_stall && m_sc != 16'hFFFF) m_sc++;
            if (PERF && e_flush && m_fc != 16'hFFFF) m_fc++;
            if (e_busy) begin
                m_wb = m_mem;
                m_mem = '{default:0};
                m_busy_left--;
            end else begin
                nid.v = id_valid; nid.rd = id_rd;
                nid.rw = id_valid & id_reg_write; nid.mr = id_valid & id_mem_read;
                if (!e_lu && !e_flush) begin
                    m_fwd_a = src(id_rs1);
                    m_fwd_b = src(id_rs2);
                end
                m_wb = m_mem;
                m_mem = m_ex;
                if (e_lu || e_flush) begin
                    m_ex = '{default:0};
                    m_busy_left = 0;
                end else begin
                    m_ex = nid;
                    m_busy_left = (id_valid && id_multi) ? LAT - 1 : 0;
                end
                m_ls = e_lu;
            end
        end
    endtask

    // One clock: check current outputs against the model, take the edge, advance the model.
    task automatic tick();
        #1;
        if (!rst) begin
            e_busy  = (m_busy_left > 0);
            e_flush = !e_busy && !m_ls && m_ex.v && ex_branch_taken;
            e_lu    = !e_busy && !m_ls && !e_flush && id_valid && m_ex.v && m_ex.mr
                      && (m_ex.rd != 0) && (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
            e_stall = e_busy || e_lu;
            chk("stall_if_id", 32'(stall_if_id), 32'(e_stall));
            chk("bubble_ex", 32'(bubble_ex), 32'(e_lu));
            chk("flush", 32'(flush), 32'(e_flush));
            chk("ex_busy", 32'(ex_busy), 32'(e_busy));
            chk("state", 32'(dbg_state), 32'(exp_state()));
            chk("ex_valid", 32'(dbg_ex.valid), 32'(m_ex.v));
            chk("ex_mem_read", 32'(dbg_ex.mem_read), 32'(m_ex.mr));
            chk("mem_valid", 32'(dbg_mem.valid), 32'(m_mem.v));
            chk("wb_valid", 32'(dbg_wb.valid), 32'(m_wb.v));
            if (m_wb.v) chk("wb_rd", 32'(dbg_wb_rd), 32'(m_wb.rd));
            if (m_ex.v || m_fresh) begin
                chk("fwd_a", 32'(fwd_a), 32'(m_fwd_a));
                chk("fwd_b", 32'(fwd_b), 32'(m_fwd_b));
            end
            chk("stall_count", 32'(stall_count), 32'(m_sc));
            chk("flush_count", 32'(flush_count), 32'(m_fc));
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drv(input bit v, input int r1, input int r2, input int d,
                       input bit w, input bit m, input bit mu, input bit b);
        id_valid = v; id_rs1 = AW'(r1); id_rs2 = AW'(r2); id_rd = AW'(d);
        id_reg_write = w; id_mem_read = m; id_multi = mu; ex_branch_taken = b;
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
        chk("rst_fwd_a", 32'(fwd_a), 32'd0);

        // Reset while a multi-cycle op is busy.
        drv(1, 0, 0, 9, 1, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
        #1 chk("busy_before_rst", 32'(ex_busy), 32'd1);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        #1;
        chk("rst2_state", 32'(dbg_state), 32'(ST_RUN));
        chk("rst2_busy", 32'(ex_busy), 32'd0);
        chk("rst2_stall", 32'(stall_if_id), 32'd0);
        chk("rst2_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        chk("rst2_slots", 32'({dbg_ex.valid, dbg_mem.valid, dbg_wb.valid}), 32'd0);
        chk("rst2_stall_cnt", 32'(stall_count), 32'd0);

        // ALU chain: MEM forward, WB forward two slots behind, rd=0 never forwards.
        drv(1, 0, 0, 1, 1, 0, 0, 0); tick();
        drv(1, 1, 2, 3, 1, 0, 0, 0); tick();
        #1 chk("alu_fwd_a_mem", 32'(fwd_a), 32'd2);
        drv(1, 4, 1, 6, 1, 0, 0, 0); tick();
        #1 chk("alu_fwd_b_wb", 32'(fwd_b), 32'd1);
        chk("alu_fwd_a_reg", 32'(fwd_a), 32'd0);
        drv(1, 0, 0, 0, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 12, 1, 0, 0, 0); tick();
        #1 chk("rd0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        drv(1, 0, 0, 14, 1, 0, 0, 0); tick();
        #1 chk("rd0_fwd_wb", 32'({fwd_a, fwd_b}), 32'd0);

        // Load-use on rs2, then on rs1.
        drv(1, 0, 0, 5, 1, 1, 0, 0); tick();
        drv(1, 7, 5, 8, 1, 0, 0, 0);
        #1 chk("lu1_stall", 32'({stall_if_id, bubble_ex}), 32'd3);
        tick();
        #1 chk("lu1_release", 32'({stall_if_id, bubble_ex}), 32'd0);
        chk("lu1_state", 32'(dbg_state), 32'(ST_LOAD_STALL));
        chk("lu1_ex_bubble", 32'(dbg_ex.valid), 32'd0);
        tick();
        #1 chk("lu1_fwd_b", 32'(fwd_b), 32'd1);
        chk("lu1_ex_valid", 32'(dbg_ex.valid), 32'd1);
        drv(1, 0, 0, 6, 1, 1, 0, 0); tick();
        drv(1, 6, 0, 9, 1, 0, 0, 0);
        #1 chk("lu2_stall", 32'(stall_if_id), 32'd1);
        tick(); tick();
        #1 chk("lu2_fwd_a", 32'(fwd_a), 32'd1);

        // Multi-cycle op: three busy cycles, MEM sees bubbles, then RUN.
        drv(1, 0, 0, 9, 1, 0, 1, 0); tick();
        drv(1, 9, 0, 10, 1, 0, 0, 0);
        for (int i = 0; i < LAT - 1; i++) begin
            #1 chk("multi_busy", 32'({ex_busy, stall_if_id}), 32'd3);
            tick();
            chk("multi_mem_bubble", 32'(dbg_mem.valid), 32'd0);
        end
        #1 chk("multi_done", 32'({ex_busy, stall_if_id}), 32'd0);
        chk("multi_state", 32'(dbg_state), 32'(ST_RUN));
        tick();
        #1 chk("multi_fwd_a", 32'(fwd_a), 32'd2);

        // Taken branch while load-use is also present: flush wins.
        drv(1, 0, 0, 5, 1, 1, 0, 0); tick();
        drv(1, 5, 0, 11, 1, 0, 0, 1);
        #1 chk("br_flush", 32'(flush), 32'd1);
        chk("br_no_stall", 32'({stall_if_id, bubble_ex}), 32'd0);
        tick();
        #1 chk("br_ex_bubble", 32'(dbg_ex.valid), 32'd0);
        chk("br_flush_once", 32'(flush), 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("perf_stall", 32'(stall_count), PERF ? 32'd5 : 32'd0);
        chk("perf_flush", 32'(flush_count), PERF ? 32'd1 : 32'd0);

        // Random instruction streams with small register indices to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            drv($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
                $urandom_range(7, 0), $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0,
                $urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0);
            rst = ($urandom_range(99, 0) == 0);
            tick();
        end
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
